// File: rtl/pio_irq_sequencer.sv
// pio_irq_sequencer
//
// Avalon-MM master that drives the control side of one input PIO slave.
// It programs the PIO interrupt mask after enable. On every irq it reads the
// data register, masks the irq off, queues the captured word in a small
// first-word-fall-through FIFO and waits a hold-off period. Then it restores
// the mask. The consumer therefore sees rate-limited events instead of an irq
// storm.
//
// Parameters
//   DEPTH    event FIFO entries (power of 2, 2..16)
//   HOLDOFF  cycles the PIO mask stays at 0 after each capture (>= 1)
//
// Ports
//   clk, reset_n        clock, asynchronous active-low reset
//   cfg_enable          1 = run, 0 = park with the PIO mask cleared
//   cfg_mask            mask value written to PIO address 2
//   pio_address/_chipselect/_write_n/_writedata   registered PIO master outputs
//   pio_readdata        PIO read data (registered in the PIO, 1-cycle latency)
//   pio_irq             PIO level interrupt
//   evt_valid/evt_ready/evt_data   event FIFO head (pop on valid & ready)
//   overflow            sticky flag: an event was dropped (cleared by reset)
//   drop_count          saturating count of dropped events
module pio_irq_sequencer #(
  parameter int DEPTH   = 4,
  parameter int HOLDOFF = 1000
) (
  input  logic        clk,
  input  logic        reset_n,
  input  logic        cfg_enable,
  input  logic [31:0] cfg_mask,
  output logic [1:0]  pio_address,
  output logic        pio_chipselect,
  output logic        pio_write_n,
  output logic [31:0] pio_writedata,
  input  logic [31:0] pio_readdata,
  input  logic        pio_irq,
  output logic        evt_valid,
  input  logic        evt_ready,
  output logic [31:0] evt_data,
  output logic        overflow,
  output logic [7:0]  drop_count
);

  localparam int PW = $clog2(DEPTH);
  localparam int CW = PW + 1;
  localparam int HW = (HOLDOFF > 1) ? $clog2(HOLDOFF) : 1;

  localparam logic [CW-1:0] DEPTH_C   = CW'(DEPTH);
  localparam logic [HW-1:0] HOLD_LOAD = HW'(HOLDOFF - 1);
  localparam logic [1:0]    ADDR_DATA = 2'd0;
  localparam logic [1:0]    ADDR_MASK = 2'd2;

  typedef enum logic [3:0] {
    ST_IDLE    = 4'd0,
    ST_INIT    = 4'd1,
    ST_ARMED   = 4'd2,
    ST_READ    = 4'd3,
    ST_CAPTURE = 4'd4,
    ST_MASKOFF = 4'd5,
    ST_HOLD    = 4'd6,
    ST_RESTORE = 4'd7,
    ST_DISABLE = 4'd8
  } state_t;

  // Saturating 8-bit increment for the drop counter.
  function automatic logic [7:0] sat_inc8(input logic [7:0] v);
    if (v == 8'hFF) begin
      return 8'hFF;
    end else begin
      return v + 8'd1;
    end
  endfunction

  state_t        state_q, state_d;
  logic [31:0]   mask_q, mask_d;
  logic [HW-1:0] hold_q, hold_d;
  logic          capture_s;

  logic          cs_q, cs_d;
  logic          wn_q, wn_d;
  logic [1:0]    addr_q, addr_d;
  logic [31:0]   wd_q, wd_d;

  logic [31:0]   mem_q [DEPTH];
  logic [PW-1:0] wr_ptr_q, wr_ptr_d;
  logic [PW-1:0] rd_ptr_q, rd_ptr_d;
  logic [CW-1:0] count_q, count_d;
  logic          push_s, pop_s, drop_s;
  logic          evt_valid_q, evt_valid_d;
  logic [31:0]   evt_data_q, evt_data_d;
  logic          overflow_q, overflow_d;
  logic [7:0]    drop_q, drop_d;

  // Sequencer next-state, latched mask and hold-off counter.
  always_comb begin
    state_d   = state_q;
    mask_d    = mask_q;
    hold_d    = hold_q;
    capture_s = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (cfg_enable) begin
          mask_d  = cfg_mask;
          state_d = ST_INIT;
        end else begin
          state_d = ST_IDLE;
        end
      end
      ST_INIT: state_d = ST_ARMED;
      ST_ARMED: begin
        // Disable wins over a simultaneous irq.
        if (!cfg_enable) begin
          state_d = ST_DISABLE;
        end else if (pio_irq) begin
          state_d = ST_READ;
        end else begin
          state_d = ST_ARMED;
        end
      end
      ST_READ: state_d = ST_CAPTURE;
      ST_CAPTURE: begin
        capture_s = 1'b1;
        state_d   = ST_MASKOFF;
      end
      ST_MASKOFF: begin
        hold_d  = HOLD_LOAD;
        state_d = ST_HOLD;
      end
      ST_HOLD: begin
        if (hold_q == {HW{1'b0}}) begin
          // The mask is already 0, so a disabled exit goes straight to IDLE.
          if (cfg_enable) begin
            state_d = ST_RESTORE;
          end else begin
            state_d = ST_IDLE;
          end
        end else begin
          hold_d = hold_q - HW'(1);
        end
      end
      ST_RESTORE: state_d = ST_ARMED;
      ST_DISABLE: state_d = ST_IDLE;
      default:    state_d = ST_IDLE;
    endcase
  end

  // PIO bus values for the state being entered, so each write appears in the
  // same cycle the sequencer occupies the writing state.
  always_comb begin
    cs_d   = 1'b0;
    wn_d   = 1'b1;
    addr_d = ADDR_DATA;
    wd_d   = 32'h0000_0000;
    case (state_d)
      ST_INIT, ST_RESTORE: begin
        cs_d   = 1'b1;
        wn_d   = 1'b0;
        addr_d = ADDR_MASK;
        wd_d   = mask_d;
      end
      ST_MASKOFF, ST_DISABLE: begin
        cs_d   = 1'b1;
        wn_d   = 1'b0;
        addr_d = ADDR_MASK;
        wd_d   = 32'h0000_0000;
      end
      default: begin
        cs_d   = 1'b0;
        wn_d   = 1'b1;
        addr_d = ADDR_DATA;
        wd_d   = 32'h0000_0000;
      end
    endcase
  end

  // Event FIFO bookkeeping; fullness is judged before any same-cycle pop.
  always_comb begin
    push_s   = capture_s && (count_q < DEPTH_C);
    drop_s   = capture_s && !(count_q < DEPTH_C);
    pop_s    = evt_valid_q && evt_ready;
    wr_ptr_d = push_s ? (wr_ptr_q + PW'(1)) : wr_ptr_q;
    rd_ptr_d = pop_s  ? (rd_ptr_q + PW'(1)) : rd_ptr_q;
    case ({push_s, pop_s})
      2'b10:   count_d = count_q + CW'(1);
      2'b01:   count_d = count_q - CW'(1);
      default: count_d = count_q;
    endcase
    evt_valid_d = (count_d != {CW{1'b0}});
    // The new head is the word being pushed only when no older entry remains.
    if (count_d == {CW{1'b0}}) begin
      evt_data_d = evt_data_q;
    end else if (push_s && (rd_ptr_d == wr_ptr_q)) begin
      evt_data_d = pio_readdata;
    end else begin
      evt_data_d = mem_q[rd_ptr_d];
    end
    overflow_d = overflow_q | drop_s;
    if (drop_s) begin
      drop_d = sat_inc8(drop_q);
    end else begin
      drop_d = drop_q;
    end
  end

  // Sequencer state, registered PIO outputs and FIFO control registers.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q     <= ST_IDLE;
      mask_q      <= 32'h0000_0000;
      hold_q      <= {HW{1'b0}};
      cs_q        <= 1'b0;
      wn_q        <= 1'b1;
      addr_q      <= 2'd0;
      wd_q        <= 32'h0000_0000;
      wr_ptr_q    <= {PW{1'b0}};
      rd_ptr_q    <= {PW{1'b0}};
      count_q     <= {CW{1'b0}};
      evt_valid_q <= 1'b0;
      evt_data_q  <= 32'h0000_0000;
      overflow_q  <= 1'b0;
      drop_q      <= 8'd0;
    end else begin
      state_q     <= state_d;
      mask_q      <= mask_d;
      hold_q      <= hold_d;
      cs_q        <= cs_d;
      wn_q        <= wn_d;
      addr_q      <= addr_d;
      wd_q        <= wd_d;
      wr_ptr_q    <= wr_ptr_d;
      rd_ptr_q    <= rd_ptr_d;
      count_q     <= count_d;
      evt_valid_q <= evt_valid_d;
      evt_data_q  <= evt_data_d;
      overflow_q  <= overflow_d;
      drop_q      <= drop_d;
    end
  end

  // Event storage.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      for (int i = 0; i < DEPTH; i++) begin
        mem_q[i] <= 32'h0000_0000;
      end
    end else begin
      if (push_s) begin
        mem_q[wr_ptr_q] <= pio_readdata;
      end
    end
  end

  assign pio_chipselect = cs_q;
  assign pio_write_n    = wn_q;
  assign pio_address    = addr_q;
  assign pio_writedata  = wd_q;
  assign evt_valid      = evt_valid_q;
  assign evt_data       = evt_data_q;
  assign overflow       = overflow_q;
  assign drop_count     = drop_q;

endmodule

// File: tb/tb_pio_irq_sequencer.sv
// Testbench for pio_irq_sequencer: a small PIO slave model, a schedule-based
// reference model of the sequencer, a per-cycle compare process and directed
// scenarios with literal expectations.
module tb_pio_irq_sequencer;

  localparam int DEPTH   = 4;
  localparam int HOLDOFF = 8;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        cfg_enable = 1'b0;
  logic [31:0] cfg_mask = 32'h0;
  logic [1:0]  pio_address;
  logic        pio_chipselect;
  logic        pio_write_n;
  logic [31:0] pio_writedata;
  logic [31:0] pio_readdata;
  logic        pio_irq;
  logic        evt_valid;
  logic        evt_ready = 1'b0;
  logic [31:0] evt_data;
  logic        overflow;
  logic [7:0]  drop_count;

  int n_checks = 0;
  int n_fail   = 0;

  pio_irq_sequencer #(.DEPTH(DEPTH), .HOLDOFF(HOLDOFF)) dut (
    .clk(clk), .reset_n(reset_n), .cfg_enable(cfg_enable), .cfg_mask(cfg_mask),
    .pio_address(pio_address), .pio_chipselect(pio_chipselect),
    .pio_write_n(pio_write_n), .pio_writedata(pio_writedata),
    .pio_readdata(pio_readdata), .pio_irq(pio_irq),
    .evt_valid(evt_valid), .evt_ready(evt_ready), .evt_data(evt_data),
    .overflow(overflow), .drop_count(drop_count)
  );

  always #5 clk = ~clk;

  // ---------------- PIO slave model ----------------
  logic [31:0] pio_in = 32'h0;
  logic [31:0] pio_mask_reg;
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      pio_mask_reg <= 32'h0;
      pio_readdata <= 32'h0;
    end else begin
      if (pio_chipselect && !pio_write_n && pio_address == 2'd2) pio_mask_reg <= pio_writedata;
      pio_readdata <= (pio_address == 2'd2) ? pio_mask_reg : ((pio_address == 2'd0) ? pio_in : 32'h0);
    end
  end
  assign pio_irq = |(pio_in & pio_mask_reg);

  // Log of completed PIO writes {addr, data}, sampled just before each edge.
  logic [33:0] wr_log[$];
  initial forever begin
    @(posedge clk);
    if (pio_chipselect && !pio_write_n) wr_log.push_back({pio_address, pio_writedata});
  end

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h, expected %h at %0t", name, act, exp, $time);
    end
  endtask

  // ---------------- Reference model ----------------
  // Timeline view: from the edge where ARMED sees irq (edge t), the capture
  // and mask-off write happen at edge t+2, and the hold-off decision happens
  // at edge t+3+HOLDOFF. Writes appear in the cycle right after the deciding edge.
  localparam int P_IDLE = 0, P_ARMED = 1, P_BUSY = 2;
  int          e = 0, m_phase = P_IDLE, m_act = 0, m_cap = 0, m_exit = 0;
  logic [31:0] m_mask = 32'h0;
  logic [31:0] mq[$];
  logic [31:0] m_evt_data = 32'h0;
  logic [31:0] m_dummy;
  bit          m_ovf = 1'b0;
  int          m_drops = 0;
  logic [35:0] x_bus = {1'b0, 1'b1, 2'd0, 32'h0};  // {cs, write_n, addr, data}
  bit          full;

  initial forever begin
    @(posedge clk or negedge reset_n);
    if (!reset_n) begin
      e = 0; m_phase = P_IDLE; m_act = 0; mq.delete(); m_evt_data = 32'h0;
      m_ovf = 1'b0; m_drops = 0; x_bus = {1'b0, 1'b1, 2'd0, 32'h0};
    end else begin
      e = e + 1;
      x_bus = {1'b0, 1'b1, 2'd0, 32'h0};
      full = (mq.size() >= DEPTH);
      if (mq.size() > 0 && evt_ready) m_dummy = mq.pop_front();
      case (m_phase)
        P_IDLE: if (e >= m_act && cfg_enable) begin
          m_mask = cfg_mask; x_bus = {1'b1, 1'b0, 2'd2, m_mask};
          m_phase = P_ARMED; m_act = e + 2;
        end
        P_ARMED: if (e >= m_act) begin
          if (!cfg_enable) begin
            x_bus = {1'b1, 1'b0, 2'd2, 32'h0}; m_phase = P_IDLE; m_act = e + 2;
          end else if (pio_irq) begin
            m_phase = P_BUSY; m_cap = e + 2; m_exit = e + 3 + HOLDOFF;
          end
        end
        default: begin
          if (e == m_cap) begin
            x_bus = {1'b1, 1'b0, 2'd2, 32'h0};
            if (!full) mq.push_back(pio_readdata);
            else begin
              m_ovf = 1'b1;
              if (m_drops < 255) m_drops = m_drops + 1;
            end
          end
          if (e == m_exit) begin
            if (cfg_enable) begin
              x_bus = {1'b1, 1'b0, 2'd2, m_mask}; m_phase = P_ARMED; m_act = e + 2;
            end else begin
              m_phase = P_IDLE; m_act = e + 1;
            end
          end
        end
      endcase
      if (mq.size() > 0) m_evt_data = mq[0];
    end
  end

  // Per-cycle comparison against the model, away from the active edge.
  initial forever begin
    @(negedge clk);
    check("pio_bus", {pio_chipselect, pio_write_n, pio_address, pio_writedata}, x_bus);
    check("evt", {evt_valid, evt_data}, {(mq.size() > 0), m_evt_data});
    check("status", {overflow, drop_count}, {m_ovf, 8'(m_drops)});
  end

  task automatic wait_write(input string name, input logic [31:0] data, input int budget);
    bit seen = 1'b0;
    for (int i = 0; i < budget && !seen; i++) begin
      @(negedge clk);
      if (pio_chipselect && !pio_write_n && pio_address == 2'd2 && pio_writedata == data) seen = 1'b1;
    end
    check(name, 64'(seen), 64'd1);
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  logic [31:0] evals[6];
  int          n0;

  initial begin
    evals[0] = 32'hA1; evals[1] = 32'hB2; evals[2] = 32'hC3;
    evals[3] = 32'hD4; evals[4] = 32'hE5; evals[5] = 32'hF6;
    repeat (3) @(negedge clk);
    check("rst_bus", {pio_chipselect, pio_write_n, pio_address, pio_writedata}, {1'b0, 1'b1, 2'd0, 32'h0});
    check("rst_evt", {evt_valid, overflow, drop_count}, 64'd0);
    reset_n = 1'b1;
    repeat (2) @(negedge clk);

    // A: enable programs the mask exactly once.
    cfg_mask = 32'h0000_00F0; cfg_enable = 1'b1;
    repeat (10) @(negedge clk);
    check("init_writes", 64'(wr_log.size()), 64'd1);
    check("init_write0", 64'(wr_log[0]), {30'd0, 2'd2, 32'hF0});

    // Single irq: latency, capture, mask-off, hold-off, restore.
    pio_in = 32'h30;
    repeat (3) @(negedge clk);
    check("maskoff_lat", {pio_chipselect, pio_write_n, pio_address, pio_writedata}, {1'b1, 1'b0, 2'd2, 32'h0});
    check("cap_evt", {evt_valid, evt_data}, {1'b1, 32'h30});
    pio_in = 32'h0;
    repeat (8) @(negedge clk);
    check("hold_quiet", 64'(pio_chipselect), 64'd0);
    @(negedge clk);
    check("restore_lat", {pio_chipselect, pio_write_n, pio_address, pio_writedata}, {1'b1, 1'b0, 2'd2, 32'hF0});
    evt_ready = 1'b1;
    @(negedge clk);
    evt_ready = 1'b0;
    check("pop_hold", {evt_valid, evt_data}, {1'b0, 32'h30});

    // B: six events into a 4-deep FIFO with no consumer.
    for (int i = 0; i < 6; i++) begin
      pio_in = evals[i];
      wait_write("b_maskoff", 32'h0, 10);
      pio_in = 32'h0;
      wait_write("b_restore", 32'hF0, 20);
      repeat (2) @(negedge clk);
    end
    check("b_status", {overflow, drop_count}, {1'b1, 8'd2});
    for (int i = 0; i < 4; i++) begin
      check("b_pop", {evt_valid, evt_data}, {1'b1, evals[i]});
      evt_ready = 1'b1;
      @(negedge clk);
    end
    evt_ready = 1'b0;
    check("b_empty", {evt_valid, evt_data}, {1'b0, 32'hD4});

    // C: disable during hold-off: no restore, then re-enable with a new mask.
    evt_ready = 1'b1;
    pio_in = 32'h55;
    wait_write("c_maskoff", 32'h0, 10);
    n0 = wr_log.size();
    pio_in = 32'h0; cfg_enable = 1'b0;
    repeat (15) @(negedge clk);
    check("c_no_restore", 64'(wr_log.size()), 64'(n0 + 1));
    check("c_pio_mask", 64'(pio_mask_reg), 64'd0);
    cfg_mask = 32'h3; cfg_enable = 1'b1;
    repeat (3) @(negedge clk);
    check("c_reinit_n", 64'(wr_log.size()), 64'(n0 + 2));
    check("c_reinit", 64'(wr_log[wr_log.size() - 1]), {30'd0, 2'd2, 32'h3});
    repeat (2) @(negedge clk);

    // D: irq and disable together in ARMED: disable wins.
    evt_ready = 1'b0;
    n0 = wr_log.size();
    pio_in = 32'h1; cfg_enable = 1'b0;
    repeat (4) @(negedge clk);
    pio_in = 32'h0;
    check("d_writes", 64'(wr_log.size()), 64'(n0 + 1));
    check("d_disable", 64'(wr_log[wr_log.size() - 1]), {30'd0, 2'd2, 32'h0});
    check("d_no_evt", 64'(evt_valid), 64'd0);

    // E: asynchronous reset in the middle of hold-off.
    cfg_mask = 32'hF0; cfg_enable = 1'b1;
    repeat (4) @(negedge clk);
    pio_in = 32'h77;
    wait_write("e_maskoff", 32'h0, 10);
    pio_in = 32'h0;
    repeat (3) @(negedge clk);
    check("e_evt", {evt_valid, evt_data}, {1'b1, 32'h77});
    #2 reset_n = 1'b0;
    #1;
    check("e_rst_bus", {pio_chipselect, pio_write_n, pio_address, pio_writedata}, {1'b0, 1'b1, 2'd0, 32'h0});
    check("e_rst_evt", {evt_valid, evt_data, overflow, drop_count}, 64'd0);
    cfg_enable = 1'b0;
    repeat (2) @(negedge clk);
    reset_n = 1'b1;
    n0 = wr_log.size();
    repeat (10) @(negedge clk);
    check("e_quiet", 64'(wr_log.size()), 64'(n0));
    check("e_idle_evt", 64'(evt_valid), 64'd0);

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
